// File: rtl/mult_hilo_sched.sv
`default_nettype none
// ============================================================================
// Module   : mult_hilo_sched
// Purpose  : Shared multi-cycle multiplier scheduler for a dual-issue pipeline.
//            Accepts MULT/MULTU from both issue slots, executes them one at a
//            time in program order (slot0 before slot1), owns the HI/LO
//            registers and stalls the front end while the unit is busy.
// Ports    : clk            - clock, rising edge
//            reset          - asynchronous, active-high
//            req0/sign0     - slot0 (older) multiply request / signed select
//            a0, b0         - slot0 operands
//            req1/sign1     - slot1 (younger) multiply request / signed select
//            a1, b1         - slot1 operands
//            mf_rd          - MFHI/MFLO in Execute
//            grant0/grant1  - request accepted this cycle (combinational)
//            stall          - freeze Fetch/Decode/Execute (combinational)
//            busy           - multiply in flight
//            done           - one-cycle pulse after HI/LO update
//            hi, lo         - architectural HI / LO
// Revision : 1.0 - initial release
// ============================================================================
module mult_hilo_sched #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        sign0,
    input  logic [31:0] a0,
    input  logic [31:0] b0,
    input  logic        req1,
    input  logic        sign1,
    input  logic [31:0] a1,
    input  logic [31:0] b1,
    input  logic        mf_rd,
    output logic        grant0,
    output logic        grant1,
    output logic        stall,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // Counter only ever holds LATENCY-1 down to 0.
    localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;

    // Active operation
    logic          act_sign;
    logic [31:0]   act_a;
    logic [31:0]   act_b;

    // Pending (younger slot of a paired issue)
    logic          pend_v;
    logic          pend_sign;
    logic [31:0]   pend_a;
    logic [31:0]   pend_b;

    logic [63:0]   ext_a;
    logic [63:0]   ext_b;
    logic [63:0]   product;
    logic          last_cycle;

    // Extending to 64 bits (sign- or zero-) and keeping the low 64 bits of
    // the product gives the correct two's-complement result in both modes.
    assign ext_a      = {{32{act_sign & act_a[31]}}, act_a};
    assign ext_b      = {{32{act_sign & act_b[31]}}, act_b};
    assign product    = ext_a * ext_b;
    assign last_cycle = (cnt == CNT_ONE);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next state and combinational outputs
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        stall      = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                grant0 = req0;
                grant1 = req1;
                if (req0 || req1) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                busy  = 1'b1;
                stall = req0 | req1 | mf_rd;
                // A queued slot1 op keeps the unit in RUN back-to-back.
                if (last_cycle && !pend_v) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: operand capture, countdown, HI/LO write-back
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            act_sign  <= 1'b0;
            act_a     <= '0;
            act_b     <= '0;
            pend_v    <= 1'b0;
            pend_sign <= 1'b0;
            pend_a    <= '0;
            pend_b    <= '0;
            hi        <= '0;
            lo        <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0) begin
                        act_sign <= sign0;
                        act_a    <= a0;
                        act_b    <= b0;
                        cnt      <= CNT_LOAD;
                        if (req1) begin
                            pend_v    <= 1'b1;
                            pend_sign <= sign1;
                            pend_a    <= a1;
                            pend_b    <= b1;
                        end
                    end else if (req1) begin
                        act_sign <= sign1;
                        act_a    <= a1;
                        act_b    <= b1;
                        cnt      <= CNT_LOAD;
                    end
                end
                RUN: begin
                    if (last_cycle) begin
                        hi   <= product[63:32];
                        lo   <= product[31:0];
                        done <= 1'b1;
                        if (pend_v) begin
                            act_sign <= pend_sign;
                            act_a    <= pend_a;
                            act_b    <= pend_b;
                            cnt      <= CNT_LOAD;
                            pend_v   <= 1'b0;
                        end else begin
                            cnt <= '0;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                default: cnt <= '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mult_hilo_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_hilo_sched
// Purpose  : Self-checking bench for mult_hilo_sched. A cycle-level reference
//            model (timestamped result queue plus an "idle from cycle" mark)
//            predicts every output every cycle for directed and random steps.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_hilo_sched;

    localparam int L = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, sign0, req1, sign1, mf_rd;
    logic [31:0] a0, b0, a1, b1;
    logic        grant0, grant1, stall, busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    mult_hilo_sched #(.LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .sign0(sign0), .a0(a0), .b0(b0),
        .req1(req1), .sign1(sign1), .a1(a1), .b1(b1),
        .mf_rd(mf_rd),
        .grant0(grant0), .grant1(grant1), .stall(stall), .busy(busy),
        .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        int          cyc;
        logic [63:0] p;
    } res_t;

    res_t        rq[$];
    int          cyc       = 0;
    int          idle_from = 0;
    logic [63:0] cur_hilo  = '0;

    function automatic logic [63:0] ref_prod(input logic s, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sp;
        if (s) begin
            sp = $signed(x) * $signed(y);
            return sp;
        end
        return {32'd0, x} * {32'd0, y};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check every output mid-cycle, advance model.
    task automatic do_cycle(input logic r0, input logic s0, input logic [31:0] x0, input logic [31:0] y0,
                            input logic r1, input logic s1, input logic [31:0] x1, input logic [31:0] y1,
                            input logic mf);
        logic idle;
        logic e_done;
        req0 = r0; sign0 = s0; a0 = x0; b0 = y0;
        req1 = r1; sign1 = s1; a1 = x1; b1 = y1;
        mf_rd = mf;
        @(negedge clk);
        idle   = (cyc >= idle_from);
        e_done = 1'b0;
        while (rq.size() > 0 && rq[0].cyc == cyc) begin
            cur_hilo = rq[0].p;
            e_done   = 1'b1;
            void'(rq.pop_front());
        end
        chk("grant0", {63'd0, grant0}, {63'd0, r0 & idle});
        chk("grant1", {63'd0, grant1}, {63'd0, r1 & idle});
        chk("stall",  {63'd0, stall},  {63'd0, ~idle & (r0 | r1 | mf)});
        chk("busy",   {63'd0, busy},   {63'd0, ~idle});
        chk("done",   {63'd0, done},   {63'd0, e_done});
        chk("hi",     {32'd0, hi},     {32'd0, cur_hilo[63:32]});
        chk("lo",     {32'd0, lo},     {32'd0, cur_hilo[31:0]});
        if (idle && r0) begin
            rq.push_back('{cyc + L, ref_prod(s0, x0, y0)});
            if (r1) begin
                rq.push_back('{cyc + 2*L - 1, ref_prod(s1, x1, y1)});
                idle_from = cyc + 2*L - 1;
            end else begin
                idle_from = cyc + L;
            end
        end else if (idle && r1) begin
            rq.push_back('{cyc + L, ref_prod(s1, x1, y1)});
            idle_from = cyc + L;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) do_cycle(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 32'd0, 0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once.
    task automatic async_reset();
        req0 = 0; req1 = 0; mf_rd = 0;
        reset = 1'b1;
        #1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hi",   {32'd0, hi},   64'd0);
        chk("rst_lo",   {32'd0, lo},   64'd0);
        @(negedge clk);
        reset = 1'b0;
        rq.delete();
        cur_hilo = '0;
        @(posedge clk);
        #1;
        cyc++;
        idle_from = cyc;
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        req0 = 0; sign0 = 0; a0 = 0; b0 = 0;
        req1 = 0; sign1 = 0; a1 = 0; b1 = 0;
        mf_rd = 0;
        #1;
        chk("init_busy", {63'd0, busy}, 64'd0);
        chk("init_hi",   {32'd0, hi},   64'd0);
        chk("init_lo",   {32'd0, lo},   64'd0);
        chk("init_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // 1: unsigned 3*5, operands changed after grant must be ignored
        do_cycle(1, 0, 32'd3, 32'd5, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 32'd9, 32'd9, 0, 0, 0, 0, 0);
        idle_cycles(3);
        chk("t1_lo", {32'd0, lo}, 64'd15);
        chk("t1_hi", {32'd0, hi}, 64'd0);

        // 2: signed and unsigned -2 * 3
        do_cycle(1, 1, 32'hFFFF_FFFE, 32'd3, 0, 0, 0, 0, 0);
        idle_cycles(L);
        chk("t2s_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
        do_cycle(1, 0, 32'hFFFF_FFFE, 32'd3, 0, 0, 0, 0, 0);
        idle_cycles(L);
        chk("t2u_hilo", {hi, lo}, 64'h0000_0002_FFFF_FFFA);

        // 3: paired issue 2*2 then 7*7
        do_cycle(1, 0, 32'd2, 32'd2, 1, 0, 32'd7, 32'd7, 0);
        idle_cycles(2*L);
        chk("t3_lo", {32'd0, lo}, 64'd49);

        // 4: MFHI/MFLO blocked behind a run
        do_cycle(1, 0, 32'd11, 32'd11, 0, 0, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 1);
        chk("t4_lo", {32'd0, lo}, 64'd121);
        idle_cycles(1);

        // 5: slot1 request held during run, re-presented until granted
        do_cycle(1, 1, 32'd5, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) do_cycle(0, 0, 0, 0, 1, 0, 32'd6, 32'd7, 0);
        idle_cycles(L);
        chk("t5_lo", {32'd0, lo}, 64'd42);

        // 6: reset in cycle 2 of a paired run
        do_cycle(1, 0, 32'd100, 32'd3, 1, 0, 32'd4, 32'd4, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        async_reset();
        idle_cycles(2*L);
        do_cycle(1, 0, 32'd8, 32'd8, 0, 0, 0, 0, 0);
        idle_cycles(L);
        chk("t6_lo", {32'd0, lo}, 64'd64);

        // Random traffic; requests and operands change freely every cycle
        for (int i = 0; i < 400; i++) begin
            if (i == 200) async_reset();
            do_cycle($urandom_range(0, 2) == 0, 1'($urandom), rand_op(), rand_op(),
                     $urandom_range(0, 2) == 0, 1'($urandom), rand_op(), rand_op(),
                     $urandom_range(0, 3) == 0);
        end
        idle_cycles(2*L);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
